// File: rtl/zoechip_pkg.sv
// Shared constants for the zoechip hex counter: display bit positions,
// the seven-segment lookup table and the mode/direction encodings.
package zoechip_pkg;

    localparam int SEG_DP = 0;
    localparam int SEG_A  = 1;
    localparam int SEG_B  = 2;
    localparam int SEG_C  = 3;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 5;
    localparam int SEG_F  = 6;
    localparam int SEG_G  = 7;

    // Entry n is the pattern for hex digit n; bit 0 = segment a ... bit 6 = segment g.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_LOAD  = 1'b1;

    localparam logic DIR_UP     = 1'b0;
    localparam logic DIR_DOWN   = 1'b1;

endpackage : zoechip_pkg

// File: rtl/zoechip_if.sv
// Pin bundle of the 8-in/8-out harness minus clk/reset: the control and
// data inputs io_in[7:2] and the registered display io_out[7:0].
interface zoechip_if;

    logic [7:2] io_in;
    logic [7:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );

endinterface : zoechip_if

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment pattern lookup.
module seg7_hex_decode
    import zoechip_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup, segment a in bit 0.
    always_comb begin
        seg = SEG_LUT[digit];
    end

endmodule : seg7_hex_decode

// File: rtl/zoechip_counter.sv
// Hex digit counter/loader driving a registered seven-segment display.
// clk and reset correspond to io_in[0] and io_in[1] of the harness.
module zoechip_counter
    import zoechip_pkg::*;
#(
    parameter int MAX_COUNT   = 1000,
    parameter int DIGIT_MAX   = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset,
    zoechip_if.slave  io
);

    localparam int             PW         = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(MAX_COUNT - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [3:0]     DIGIT_TOP  = 4'(DIGIT_MAX);

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic                        edge_q, edge_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [3:0]                  digit_q, digit_d;
    logic                        dp_q, dp_d;
    logic [7:0]                  out_q, out_d;
    logic [6:0]                  seg_s;
    logic                        mode_s;
    logic                        ld_s;
    logic [3:0]                  data_s;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        if (d > DIGIT_TOP) begin
            return DIGIT_TOP;
        end else begin
            return d;
        end
    endfunction

    assign mode_s = sync_q[SYNC_STAGES-1][5];
    assign ld_s   = sync_q[SYNC_STAGES-1][4];
    assign data_s = sync_q[SYNC_STAGES-1][3:0];

    seg7_hex_decode u_decode (
        .digit (digit_q),
        .seg   (seg_s)
    );

    // Next-state logic: synchroniser shift, prescaler, digit/dp update and display.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = io.io_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        edge_d  = ld_s;
        presc_d = presc_q;
        digit_d = digit_q;
        dp_d    = dp_q;

        if (mode_s == MODE_COUNT) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = {PW{1'b0}};
                // ld_s doubles as direction; it only matters on the step edge.
                if (ld_s == DIR_DOWN) begin
                    if (digit_q == 4'd0) begin
                        digit_d = DIGIT_TOP;
                        dp_d    = ~dp_q;
                    end else begin
                        digit_d = digit_q - 4'd1;
                    end
                end else begin
                    if (digit_q >= DIGIT_TOP) begin
                        digit_d = 4'd0;
                        dp_d    = ~dp_q;
                    end else begin
                        digit_d = digit_q + 4'd1;
                    end
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = {PW{1'b0}};
            if (ld_s && !edge_q) begin
                digit_d = sat_digit(data_s);
            end else begin
                digit_d = digit_q;
            end
        end

        out_d               = 8'h00;
        out_d[SEG_G:SEG_A]  = seg_s;
        out_d[SEG_DP]       = dp_q;
    end

    // State registers; synchronous reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '{default: 6'd0};
            edge_q  <= 1'b0;
            presc_q <= {PW{1'b0}};
            digit_q <= 4'd0;
            dp_q    <= 1'b0;
            out_q   <= 8'h00;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            out_q   <= out_d;
        end
    end

    assign io.io_out = out_q;

endmodule : zoechip_counter
